// File: rtl/mem_pkg.sv
// Shared types, op codes and byte-lane helpers for the MEM-stage SRAM access unit.
// Optional feature macro: MEM_ALIGN_CHECK_EN (word-access alignment trap).
package mem_pkg;

  localparam int unsigned AluOpW   = 8;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned SramAW   = 32;  // incoming byte address
  localparam int unsigned SramDW   = 32;
  localparam int unsigned WaitCntW = 3;

  // ALU op codes as issued by the EX stage
  localparam logic [AluOpW-1:0] EXE_NOP_OP  = 8'h00;
  localparam logic [AluOpW-1:0] EXE_ADDU_OP = 8'h21;
  localparam logic [AluOpW-1:0] EXE_LB_OP   = 8'he0;
  localparam logic [AluOpW-1:0] EXE_LBU_OP  = 8'he4;
  localparam logic [AluOpW-1:0] EXE_LW_OP   = 8'he3;
  localparam logic [AluOpW-1:0] EXE_SB_OP   = 8'he8;
  localparam logic [AluOpW-1:0] EXE_SW_OP   = 8'heb;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} mem_state_e;

  function automatic logic is_load(input logic [AluOpW-1:0] op);
    return (op == EXE_LW_OP) || (op == EXE_LB_OP) || (op == EXE_LBU_OP);
  endfunction

  function automatic logic is_store(input logic [AluOpW-1:0] op);
    return (op == EXE_SW_OP) || (op == EXE_SB_OP);
  endfunction

  function automatic logic is_word(input logic [AluOpW-1:0] op);
    return (op == EXE_LW_OP) || (op == EXE_SW_OP);
  endfunction

  // Active-low byte enables: only SB narrows the access; loads read the whole word
  function automatic logic [3:0] lane_be_n(input logic [AluOpW-1:0] op, input logic [1:0] lane);
    return (op == EXE_SB_OP) ? ~(4'b0001 << lane) : 4'h0;
  endfunction

  function automatic logic [SramDW-1:0] load_extend(input logic [AluOpW-1:0] op,
                                                    input logic [1:0] lane,
                                                    input logic [SramDW-1:0] word);
    logic [7:0] b;
    b = word[{lane, 3'b000} +: 8];
    if (op == EXE_LB_OP) return {{24{b[7]}}, b};
    if (op == EXE_LBU_OP) return {24'h0, b};
    return word;
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane steering: byte enables, store replication, load extension.
module mem_byte_lane
  import mem_pkg::*;
(
  input  logic [AluOpW-1:0] op,
  input  logic [1:0]        lane,
  input  logic [SramDW-1:0] wdata,
  input  logic [SramDW-1:0] rdata,
  output logic [3:0]        be_n,
  output logic [SramDW-1:0] wdata_rep,
  output logic [SramDW-1:0] rdata_ext
);

  // Lane decode for both directions of the access
  always_comb begin
    be_n      = lane_be_n(op, lane);
    wdata_rep = (op == EXE_SB_OP) ? {4{wdata[7:0]}} : wdata;
    rdata_ext = load_extend(op, lane, rdata);
  end

endmodule

// File: rtl/mem_sram_access.sv
// MEM-stage access unit: multi-cycle word/byte accesses on an asynchronous SRAM with a
// pipeline stall request. Optional macro MEM_ALIGN_CHECK_EN traps misaligned LW/SW.
module mem_sram_access
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [AluOpW-1:0]   MEM_ALU_OP,
  input  logic                MEM_GPR_WE,
  input  logic [RegAddrW-1:0] MEM_GPR_WADDR,
  input  logic [RegDataW-1:0] MEM_GPR_WDATA,
  input  logic [SramAW-1:0]   MEM_SRAM_ADDR,
  input  logic [SramDW-1:0]   MEM_SRAM_WDATA,
  output logic                WB_GPR_WE,
  output logic [RegAddrW-1:0] WB_GPR_WADDR,
  output logic [RegDataW-1:0] WB_GPR_WDATA,
  output logic                STALL_REQ_MEM,
  output logic [19:0]         SRAM_ADDR,
  input  logic [SramDW-1:0]   SRAM_DQ_I,
  output logic [SramDW-1:0]   SRAM_DQ_O,
  output logic                SRAM_DQ_OE,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic [3:0]          SRAM_BE_N,
  output logic                ADDR_ERR
);

  localparam logic RST_EN = 1'b0;
  localparam logic [WaitCntW-1:0] WaitInit = WaitCntW'(WAIT_CYCLES);

  mem_state_e          state_q;
  logic [WaitCntW-1:0] cnt_q;
  logic [AluOpW-1:0]   op_q;
  logic [1:0]          lane_q;
  logic [SramDW-1:0]   rdata_q;

  logic                run, mem_op, misalign, start;
  logic [AluOpW-1:0]   bl_op;
  logic [1:0]          bl_lane;
  logic [3:0]          bl_be_n;
  logic [SramDW-1:0]   bl_wdata, bl_rdata;
  logic                unused_addr;

  assign unused_addr = ^MEM_SRAM_ADDR[SramAW-1:22];
  assign run    = (RST != RST_EN);
  assign mem_op = is_load(MEM_ALU_OP) || is_store(MEM_ALU_OP);
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_word(MEM_ALU_OP) && (MEM_SRAM_ADDR[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign start = run && (state_q == StIdle) && mem_op && !misalign;

  // Steer from the live op while idle, from the latched op once the access is under way
  assign bl_op   = (state_q == StIdle) ? MEM_ALU_OP : op_q;
  assign bl_lane = (state_q == StIdle) ? MEM_SRAM_ADDR[1:0] : lane_q;

  mem_byte_lane u_byte_lane (
    .op        (bl_op),
    .lane      (bl_lane),
    .wdata     (MEM_SRAM_WDATA),
    .rdata     (rdata_q),
    .be_n      (bl_be_n),
    .wdata_rep (bl_wdata),
    .rdata_ext (bl_rdata)
  );

  // Access FSM with registered SRAM strobes, address, byte enables and store data
  always_ff @(posedge CLK) begin
    if (RST == RST_EN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= EXE_NOP_OP;
      lane_q     <= 2'b00;
      rdata_q    <= '0;
      SRAM_ADDR  <= '0;
      SRAM_DQ_O  <= '0;
      SRAM_DQ_OE <= 1'b0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_BE_N  <= 4'hF;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StAccess;
            cnt_q      <= WaitInit;
            op_q       <= MEM_ALU_OP;
            lane_q     <= MEM_SRAM_ADDR[1:0];
            SRAM_ADDR  <= MEM_SRAM_ADDR[21:2];
            SRAM_BE_N  <= bl_be_n;
            SRAM_CE_N  <= 1'b0;
            SRAM_OE_N  <= !is_load(MEM_ALU_OP);
            SRAM_WE_N  <= !is_store(MEM_ALU_OP);
            SRAM_DQ_OE <= is_store(MEM_ALU_OP);
            if (is_store(MEM_ALU_OP)) SRAM_DQ_O <= bl_wdata;
          end
        end
        StAccess: begin
          if (cnt_q == '0) begin
            if (is_load(op_q)) rdata_q <= SRAM_DQ_I;
            state_q    <= StDone;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stall request and write-back selection
  always_comb begin
    STALL_REQ_MEM = start || (run && (state_q == StAccess));
    ADDR_ERR      = run && (state_q == StIdle) && misalign;
    WB_GPR_WE     = MEM_GPR_WE;
    WB_GPR_WADDR  = MEM_GPR_WADDR;
    WB_GPR_WDATA  = MEM_GPR_WDATA;
    if (state_q == StDone) begin
      if (is_load(op_q)) WB_GPR_WDATA = bl_rdata;
      else               WB_GPR_WE    = 1'b0;
    end else if (mem_op) begin
      // No write-back until the access completes (or ever, if trapped)
      WB_GPR_WE = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_sram_access.sv
// Directed bench for mem_sram_access with a small behavioural SRAM (WAIT_CYCLES=1).
module tb_mem_sram_access;
  import mem_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [7:0]  MEM_ALU_OP = EXE_NOP_OP;
  logic        MEM_GPR_WE = 1'b0;
  logic [4:0]  MEM_GPR_WADDR = '0;
  logic [31:0] MEM_GPR_WDATA = '0, MEM_SRAM_ADDR = '0, MEM_SRAM_WDATA = '0;
  logic        WB_GPR_WE, STALL_REQ_MEM, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, ADDR_ERR;
  logic [4:0]  WB_GPR_WADDR;
  logic [31:0] WB_GPR_WDATA, SRAM_DQ_I, SRAM_DQ_O;
  logic [19:0] SRAM_ADDR;
  logic [3:0]  SRAM_BE_N;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  mem_sram_access #(.WAIT_CYCLES(1)) dut (
    .CLK(CLK), .RST(RST), .MEM_ALU_OP(MEM_ALU_OP), .MEM_GPR_WE(MEM_GPR_WE),
    .MEM_GPR_WADDR(MEM_GPR_WADDR), .MEM_GPR_WDATA(MEM_GPR_WDATA),
    .MEM_SRAM_ADDR(MEM_SRAM_ADDR), .MEM_SRAM_WDATA(MEM_SRAM_WDATA),
    .WB_GPR_WE(WB_GPR_WE), .WB_GPR_WADDR(WB_GPR_WADDR), .WB_GPR_WDATA(WB_GPR_WDATA),
    .STALL_REQ_MEM(STALL_REQ_MEM), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_I(SRAM_DQ_I),
    .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_BE_N(SRAM_BE_N), .ADDR_ERR(ADDR_ERR)
  );

  // Behavioural SRAM: 16 words, byte-masked synchronous write model, async read
  logic [31:0] sram [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge CLK) begin
    if (pre_en) sram[pre_idx] <= pre_val;
    else if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_OE)
      for (int b = 0; b < 4; b++)
        if (!SRAM_BE_N[b]) sram[SRAM_ADDR[3:0]][b*8 +: 8] <= SRAM_DQ_O[b*8 +: 8];
  end
  assign SRAM_DQ_I = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[3:0]] : 32'h0;

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge CLK); #1;
    pre_en = 1'b0;
  endtask

  task automatic drive(input logic [7:0] op, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] addr, input logic [31:0] sd);
    MEM_ALU_OP = op; MEM_GPR_WE = we; MEM_GPR_WADDR = wa; MEM_GPR_WDATA = wd;
    MEM_SRAM_ADDR = addr; MEM_SRAM_WDATA = sd;
  endtask

  // Runs one memory op from IDLE to DONE and reports what was observed (no checking here)
  task automatic mem_txn(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] gd, output int n_stall, output int n_we,
                         output int n_oe, output logic d_we, output logic [31:0] d_wdata,
                         output logic [19:0] a_addr, output logic [3:0] a_be,
                         output logic [31:0] a_dq, output logic stable, output logic tmo);
    logic seen;
    n_stall = 0; n_we = 0; n_oe = 0; d_we = 1'bx; d_wdata = 'x;
    a_addr = 'x; a_be = 'x; a_dq = 'x; stable = 1'b1; tmo = 1'b1; seen = 1'b0;
    drive(op, 1'b1, 5'd7, gd, addr, sd);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (!STALL_REQ_MEM) begin
        d_we = WB_GPR_WE; d_wdata = WB_GPR_WDATA; tmo = 1'b0;
        break;
      end
      n_stall++;
      if (!SRAM_CE_N) begin
        if (!seen) begin
          a_addr = SRAM_ADDR; a_be = SRAM_BE_N; a_dq = SRAM_DQ_O; seen = 1'b1;
        end else if (SRAM_ADDR !== a_addr || SRAM_BE_N !== a_be || SRAM_DQ_O !== a_dq) begin
          stable = 1'b0;
        end
        if (!SRAM_WE_N) n_we++;
        if (!SRAM_OE_N) n_oe++;
      end
    end
    @(posedge CLK); #1;
    drive(EXE_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N} !== 3'b111) begin failures++;
      $display("FAIL reset_strobes: got %b expected 111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N}); end
    checks++; if (SRAM_BE_N !== 4'hF) begin failures++;
      $display("FAIL reset_be_n: got %h expected f", SRAM_BE_N); end
    checks++; if ({SRAM_DQ_OE, SRAM_DQ_O, SRAM_ADDR} !== 53'h0) begin failures++;
      $display("FAIL reset_dq_addr: oe %b dq %h addr %h expected zeros",
               SRAM_DQ_OE, SRAM_DQ_O, SRAM_ADDR); end
    checks++; if ({STALL_REQ_MEM, ADDR_ERR} !== 2'b00) begin failures++;
      $display("FAIL reset_stall_err: got %b expected 00", {STALL_REQ_MEM, ADDR_ERR}); end
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

  task automatic test_passthrough();
    int stalls = 0;
    @(posedge CLK); #1;
    drive(EXE_ADDU_OP, 1'b1, 5'd3, 32'h0000_0042, 32'h0000_0010, 32'h0);
    #1;
    checks++; if ({WB_GPR_WE, WB_GPR_WADDR, WB_GPR_WDATA} !== {1'b1, 5'd3, 32'h42}) begin
      failures++; $display("FAIL addu_wb: got we %b wa %0d wd %h expected 1 3 00000042",
                           WB_GPR_WE, WB_GPR_WADDR, WB_GPR_WDATA); end
    repeat (3) begin
      @(negedge CLK);
      if (STALL_REQ_MEM || !SRAM_CE_N) stalls++;
    end
    checks++; if (stalls !== 0) begin failures++;
      $display("FAIL addu_no_stall: got %0d busy cycles expected 0", stalls); end
    drive(EXE_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_store_word();
    int ns, nw, no; logic dwe, st, tmo; logic [31:0] dwd, adq; logic [19:0] aa; logic [3:0] abe;
    @(posedge CLK); #1;
    mem_txn(EXE_SW_OP, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5555_5555,
            ns, nw, no, dwe, dwd, aa, abe, adq, st, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL sw_timeout: got %b expected 0", tmo); end
    checks++; if (ns !== 3) begin failures++; $display("FAIL sw_stall: got %0d expected 3", ns); end
    checks++; if (nw !== 2) begin failures++; $display("FAIL sw_we_low: got %0d expected 2", nw); end
    checks++; if ({aa, abe} !== {20'h00004, 4'h0}) begin failures++;
      $display("FAIL sw_addr_be: got %h %h expected 00004 0", aa, abe); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL sw_stable: got %b expected 1", st); end
    checks++; if (dwe !== 1'b0) begin failures++; $display("FAIL sw_wb_we: got %b expected 0", dwe); end
    checks++; if (sram[4] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL sw_mem: got %h expected deadbeef", sram[4]); end
  endtask

  task automatic test_load_byte();
    int ns, nw, no; logic dwe, st, tmo; logic [31:0] dwd, adq; logic [19:0] aa; logic [3:0] abe;
    preload(4'd4, 32'h80FF_1234);
    mem_txn(EXE_LB_OP, 32'h0000_0013, 32'h0, 32'h1111_1111,
            ns, nw, no, dwe, dwd, aa, abe, adq, st, tmo);
    checks++; if ({tmo, ns, no} !== {1'b0, 32'd3, 32'd2}) begin failures++;
      $display("FAIL lb_timing: got tmo %b stall %0d oe %0d expected 0 3 2", tmo, ns, no); end
    checks++; if ({dwe, dwd} !== {1'b1, 32'hFFFF_FF80}) begin failures++;
      $display("FAIL lb_data: got we %b %h expected 1 ffffff80", dwe, dwd); end
    mem_txn(EXE_LBU_OP, 32'h0000_0013, 32'h0, 32'h1111_1111,
            ns, nw, no, dwe, dwd, aa, abe, adq, st, tmo);
    checks++; if ({tmo, dwe, dwd} !== {1'b0, 1'b1, 32'h0000_0080}) begin failures++;
      $display("FAIL lbu_data: got tmo %b we %b %h expected 0 1 00000080", tmo, dwe, dwd); end
  endtask

  task automatic test_store_byte();
    int ns, nw, no; logic dwe, st, tmo; logic [31:0] dwd, adq; logic [19:0] aa; logic [3:0] abe;
    preload(4'd8, 32'h1122_3344);
    mem_txn(EXE_SB_OP, 32'h0000_0021, 32'h1234_565A, 32'h0,
            ns, nw, no, dwe, dwd, aa, abe, adq, st, tmo);
    checks++; if ({tmo, aa, abe} !== {1'b0, 20'h00008, 4'b1101}) begin failures++;
      $display("FAIL sb_addr_be: got tmo %b %h %b expected 0 00008 1101", tmo, aa, abe); end
    checks++; if (adq !== 32'h5A5A_5A5A) begin failures++;
      $display("FAIL sb_dq: got %h expected 5a5a5a5a", adq); end
    checks++; if (sram[8] !== 32'h1122_5A44) begin failures++;
      $display("FAIL sb_mem: got %h expected 11225a44", sram[8]); end
  endtask

  task automatic test_back_to_back();
    int stalls = 0, windows = 0, gap = 0, phase = 0;
    logic prev_ce = 1'b1, lw_we = 1'b0, done = 1'b0;
    logic [31:0] lw_data = '0;
    preload(4'd9, 32'hCAFE_F00D);
    drive(EXE_LW_OP, 1'b1, 5'd9, 32'h0, 32'h0000_0024, 32'h0);
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge CLK);
      if (!SRAM_CE_N && prev_ce) windows++;
      if (SRAM_CE_N && windows == 1) gap++;
      prev_ce = SRAM_CE_N;
      if (STALL_REQ_MEM) stalls++;
      else if (phase == 0) begin
        lw_we = WB_GPR_WE; lw_data = WB_GPR_WDATA; phase = 1;
        @(posedge CLK); #1;
        drive(EXE_SW_OP, 1'b1, 5'd0, 32'h0, 32'h0000_0028, 32'h0BAD_F00D);
      end else done = 1'b1;
    end
    @(posedge CLK); #1;
    drive(EXE_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_timeout: got %b expected 1", done); end
    checks++; if ({lw_we, lw_data} !== {1'b1, 32'hCAFE_F00D}) begin failures++;
      $display("FAIL b2b_lw: got we %b %h expected 1 cafef00d", lw_we, lw_data); end
    checks++; if (stalls !== 6) begin failures++; $display("FAIL b2b_stall: got %0d expected 6", stalls); end
    checks++; if (windows !== 2) begin failures++; $display("FAIL b2b_windows: got %0d expected 2", windows); end
    checks++; if (!(gap >= 1)) begin failures++; $display("FAIL b2b_gap: got %0d expected >=1", gap); end
    checks++; if (sram[10] !== 32'h0BAD_F00D) begin failures++;
      $display("FAIL b2b_sw_mem: got %h expected 0badf00d", sram[10]); end
  endtask

  task automatic test_reset_mid_access();
    logic hit = 1'b0;
    @(posedge CLK); #1;
    drive(EXE_SW_OP, 1'b1, 5'd1, 32'h0, 32'h0000_0030, 32'h1234_5678);
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge CLK);
      if (!SRAM_WE_N) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL rst_mid_reach: got %b expected 1", hit); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if ({SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE} !== 3'b110) begin failures++;
      $display("FAIL rst_mid_strobes: got %b expected 110", {SRAM_WE_N, SRAM_CE_N, SRAM_DQ_OE}); end
    checks++; if ({STALL_REQ_MEM, WB_GPR_WE} !== 2'b00) begin failures++;
      $display("FAIL rst_mid_stall_wb: got %b expected 00", {STALL_REQ_MEM, WB_GPR_WE}); end
    drive(EXE_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b1;
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_align();
    @(posedge CLK); #1;
    drive(EXE_LW_OP, 1'b1, 5'd2, 32'h0, 32'h0000_0002, 32'h0);
    @(negedge CLK);
    checks++; if ({ADDR_ERR, STALL_REQ_MEM, WB_GPR_WE} !== 3'b100) begin failures++;
      $display("FAIL align_trap: got %b expected 100", {ADDR_ERR, STALL_REQ_MEM, WB_GPR_WE}); end
    @(negedge CLK);
    checks++; if (SRAM_CE_N !== 1'b1) begin failures++;
      $display("FAIL align_no_access: got %b expected 1", SRAM_CE_N); end
    drive(EXE_NOP_OP, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask
`else
  task automatic test_align();
    int ns, nw, no; logic dwe, st, tmo; logic [31:0] dwd, adq; logic [19:0] aa; logic [3:0] abe;
    logic err = 1'b0;
    preload(4'd0, 32'h1357_9BDF);
    fork
      mem_txn(EXE_LW_OP, 32'h0000_0002, 32'h0, 32'h0,
              ns, nw, no, dwe, dwd, aa, abe, adq, st, tmo);
      repeat (5) begin @(negedge CLK); if (ADDR_ERR) err = 1'b1; end
    join
    checks++; if ({tmo, ns, err} !== {1'b0, 32'd3, 1'b0}) begin failures++;
      $display("FAIL align_ignored: got tmo %b stall %0d err %b expected 0 3 0", tmo, ns, err); end
    checks++; if (dwd !== 32'h1357_9BDF) begin failures++;
      $display("FAIL align_lw_data: got %h expected 13579bdf", dwd); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_store_word();
    test_load_byte();
    test_store_byte();
    test_back_to_back();
    test_reset_mid_access();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
